// File: rtl/three_input_nand_sweep_controller.sv
// Exhaustive sweep sequencer for an N-input NAND gate: walks every input vector,
// holds it for a settle window, then checks the gate output against ~&vector.
//
// state  | meaning
// IDLE   | waiting for start; results of the last sweep are held
// SETTLE | current vector driven, waiting HOLD_CYCLES for the gate to settle
// CHECK  | one cycle: compare gate_out with ~&gate_in, advance or finish
// DONE   | one cycle: done pulse, pass reflects the completed sweep
module three_input_nand_sweep_controller #(
  parameter int N           = 3,
  parameter int HOLD_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  output logic [N-1:0] gate_in,
  input  logic         gate_out,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   err_count,
  output logic [N-1:0] fail_vec
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic          mismatch;
  logic          last_vec;

  assign mismatch = (gate_out != ~(&gate_in));
  assign last_vec = &gate_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      gate_in   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_vec  <= '0;
      hold_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            gate_in   <= '0;
            err_count <= '0;
            fail_vec  <= '0;
            pass      <= 1'b0;
            hold_cnt  <= '0;
            busy      <= 1'b1;
            state     <= S_SETTLE;
          end
        end

        S_SETTLE: begin
          if (abort) begin
            gate_in  <= '0;
            pass     <= 1'b0;
            busy     <= 1'b0;
            hold_cnt <= '0;
            state    <= S_IDLE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
            if (hold_cnt == HOLD_LAST) state <= S_CHECK;
          end
        end

        S_CHECK: begin
          // An abort here discards this cycle's comparison entirely.
          if (abort) begin
            gate_in  <= '0;
            pass     <= 1'b0;
            busy     <= 1'b0;
            hold_cnt <= '0;
            state    <= S_IDLE;
          end else begin
            if (mismatch) begin
              err_count <= err_count + 1'b1;
              if (err_count == '0) fail_vec <= gate_in;
            end
            if (last_vec) begin
              // pass is settled alongside the done pulse, folding in this final check.
              pass  <= (err_count == '0) && !mismatch;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              gate_in  <= gate_in + 1'b1;
              hold_cnt <= '0;
              state    <= S_SETTLE;
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
